// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with an occupancy count, programmable almost flags,
// sticky overflow/underflow flags and a standard or first-word-fall-through read port.
module fifo_sync_prog #(
  parameter int unsigned W_DATA = 8,
  parameter int unsigned W_ADDR = 3,
  parameter int unsigned FWFT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [W_DATA-1:0] data_in,
  input  logic              pop,
  output logic [W_DATA-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [W_ADDR:0]   count,
  input  logic [W_ADDR:0]   af_thresh,
  input  logic [W_ADDR:0]   ae_thresh,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int unsigned DEPTH = 1 << W_ADDR;

  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_ADDR:0]   wptr;
  logic [W_ADDR:0]   rptr;
  logic [W_ADDR:0]   af_q;
  logic [W_ADDR:0]   ae_q;
  logic              push_ok;
  logic              pop_ok;
  logic              ovf_set;
  logic              unf_set;

  // Full when the wrap bits differ but the addresses coincide; equivalent to count == DEPTH.
  assign full  = (wptr[W_ADDR] != rptr[W_ADDR]) &&
                 (wptr[W_ADDR-1:0] == rptr[W_ADDR-1:0]);
  assign empty = (count == '0);

  // Thresholds are registered so a change shows up on the flags one cycle later.
  assign almost_full  = (count >= af_q);
  assign almost_empty = (count <= ae_q);

  // A push into a full FIFO is still taken when a pop frees the head slot in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf_set = push & ~push_ok;
  assign unf_set = pop & ~pop_ok;

  always_ff @(posedge clk) begin
    af_q <= af_thresh;
    ae_q <= ae_thresh;
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wptr[W_ADDR-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A fresh error in the clearing cycle keeps its flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= ovf_set;
      underflow <= unf_set;
    end else begin
      overflow  <= overflow | ovf_set;
      underflow <= underflow | unf_set;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rptr[W_ADDR-1:0]];
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out <= '0;
        end else if (pop_ok) begin
          data_out <= mem[rptr[W_ADDR-1:0]];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: a standard-read and an FWFT instance share one stimulus
// stream and are checked against a queue model of the FIFO.
module tb_fifo_sync_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic       pop;
  logic       err_clr;
  logic [7:0] data_in;
  logic [3:0] af_thresh;
  logic [3:0] ae_thresh;

  logic [7:0] d0, d1;
  logic [3:0] cnt0, cnt1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] m_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_sync_prog #(.W_DATA(8), .W_ADDR(3), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
    .data_out(d0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(ovf0), .underflow(unf0), .err_clr(err_clr)
  );

  fifo_sync_prog #(.W_DATA(8), .W_ADDR(3), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .push(push), .data_in(data_in), .pop(pop),
    .data_out(d1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(ovf1), .underflow(unf1), .err_clr(err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the standard-read instance accepts a pop, its data_out is
  // checked one step after the edge against the oldest expected word.
  always @(posedge clk) begin
    if (!rst && pop && !empty0) begin
      #1;
      if (exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else                   check("rd_data", {24'd0, d0}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic check_all();
    int         sz;
    logic [5:0] exp_flags;
    logic [7:0] head;
    sz = mq.size();
    head = (sz == 0) ? 8'h00 : mq[0];
    exp_flags = {sz == 8, sz == 0, sz >= int'(af_thresh), sz <= int'(ae_thresh), m_ovf, m_unf};
    check("count_std",  {28'd0, cnt0}, sz);
    check("count_fwft", {28'd0, cnt1}, sz);
    check("flags_std",  {26'd0, full0, empty0, af0, ae0, ovf0, unf0}, {26'd0, exp_flags});
    check("flags_fwft", {26'd0, full1, empty1, af1, ae1, ovf1, unf1}, {26'd0, exp_flags});
    check("dout_std",   {24'd0, d0}, {24'd0, m_dout});
    check("dout_fwft",  {24'd0, d1}, {24'd0, head});
  endtask

  // Drives one cycle from a negedge, advances the model, then checks at the next negedge.
  task automatic step(input logic p, input logic [7:0] d, input logic q,
                      input logic c, input logic r);
    int   sz;
    logic pu, pk;
    push = p; data_in = d; pop = q; err_clr = c; rst = r;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = 8'h00;
    end else begin
      sz = mq.size();
      pu = q && (sz != 0);
      pk = p && ((sz != 8) || pu);
      if (pu) begin
        m_dout = mq.pop_front();
        exp_q.push_back(m_dout);
      end
      if (pk) mq.push_back(d);
      if (c) begin
        m_ovf = p && !pk;
        m_unf = q && !pu;
      end else begin
        m_ovf = m_ovf | (p && !pk);
        m_unf = m_unf | (q && !pu);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int pbias;
    push = 0; pop = 0; err_clr = 0; rst = 1; data_in = 0;
    af_thresh = 4'd0; ae_thresh = 4'd1;
    m_ovf = 0; m_unf = 0; m_dout = 0;

    // Reset with af_thresh = 0 sets almost_full; restoring 6 clears it a cycle later.
    step(0, 8'h00, 0, 0, 1);
    af_thresh = 4'd6;
    step(0, 8'h00, 0, 0, 0);

    // Fill 0x01..0x08, then a lone push while full overflows.
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'hAB, 0, 1, 0);           // new error during clear keeps the flag
    step(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);

    // Full with push+pop: count holds, 0x55 comes out last, pointers wrap.
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);

    // Empty pop underflows; push+pop on empty accepts only the push.
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h33, 1, 0, 0);
    step(0, 8'h00, 1, 1, 0);

    // FWFT push into empty, then pop back to empty.
    step(1, 8'h7E, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Reset at count 4 discards data; first word after reset reads back.
    for (int i = 0; i < 4; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
    step(1, 8'hEE, 1, 0, 1);
    step(1, 8'h11, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Randomised traffic with phased push bias to reach both full and empty.
    for (int i = 0; i < 600; i++) begin
      pbias = ((i / 40) % 2 == 0) ? 80 : 25;
      if ($urandom_range(0, 39) == 0) af_thresh = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 39) == 0) ae_thresh = 4'($urandom_range(0, 9));
      step($urandom_range(0, 99) < pbias, 8'($urandom_range(0, 255)),
           $urandom_range(0, 99) < (105 - pbias), $urandom_range(0, 19) == 0,
           $urandom_range(0, 199) == 0);
    end

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
